// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake with error short-cuts.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_overflow;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_prem_next;
    logic             w_last;
    logic             w_zero_div;
    logic             w_ovf;

    // The partial remainder stays below the divisor, so it fits WIDTH bits;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        w_trial     = {r_prem, r_shift[WIDTH-1]};
        w_qbit      = (w_trial >= {1'b0, r_divisor});
        w_diff      = w_trial[WIDTH-1:0] - r_divisor;
        w_prem_next = w_qbit ? w_diff : w_trial[WIDTH-1:0];
        w_last      = (r_count == CW'(WIDTH - 1));
        w_zero_div  = (divisor == '0);
        w_ovf       = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (w_zero_div || w_ovf) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_prem        <= '0;
            r_shift       <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_divisor <= divisor;
                        if (w_zero_div) begin
                            r_quotient    <= '1;
                            r_remainder   <= dividend[WIDTH-1:0];
                            r_div_by_zero <= 1'b1;
                            r_overflow    <= 1'b0;
                        end else if (w_ovf) begin
                            r_quotient    <= '1;
                            r_remainder   <= '0;
                            r_div_by_zero <= 1'b0;
                            r_overflow    <= 1'b1;
                        end else begin
                            r_prem        <= dividend[2*WIDTH-1:WIDTH];
                            r_shift       <= dividend[WIDTH-1:0];
                            r_count       <= '0;
                            r_div_by_zero <= 1'b0;
                            r_overflow    <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    r_prem  <= w_prem_next;
                    r_shift <= {r_shift[WIDTH-2:0], w_qbit};
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_quotient  <= {r_shift[WIDTH-2:0], w_qbit};
                        r_remainder <= w_prem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and held-start regression bench for seq_divider.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present operands with start high across one edge (E0), then drop start.
    task automatic begin_op(input logic [31:0] dvd, input logic [15:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Edges after E0 until done is seen (0 means done in the cycle after E0).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov);
        int n;
        begin_op(dvd, dvs);
        wait_done(n);
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".busy"}, 64'(busy), 64'd1);
        check({tag, ".quotient"}, 64'(quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(remainder), 64'(er));
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edz));
        check({tag, ".overflow"}, 64'(overflow), 64'(eov));
        $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d ov=%0d lat=%0d",
                 tag, dvd, dvs, quotient, remainder, div_by_zero, overflow, n);
        @(posedge clk); #1;
        check({tag, ".idle_done"}, 64'(done), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy), 64'd0);
        check({tag, ".hold_q"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        int n;
        int last_done;
        int cyc;
        logic [31:0] dvd;
        logic [15:0] dvs;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.flags", 64'({div_by_zero, overflow}), 64'd0);

        run_op("basic",   32'd200,        16'd20,    16, 16'd10,    16'd0,      1'b0, 1'b0);
        run_op("maxexact",32'hFFFE0001,   16'hFFFF,  16, 16'hFFFF,  16'd0,      1'b0, 1'b0);
        run_op("maxrem",  32'hFFFEFFFF,   16'hFFFF,  16, 16'hFFFF,  16'hFFFE,   1'b0, 1'b0);
        run_op("divzero", 32'h00001234,   16'd0,     0,  16'hFFFF,  16'h1234,   1'b1, 1'b0);
        run_op("clearflag",32'd200,       16'd20,    16, 16'd10,    16'd0,      1'b0, 1'b0);
        run_op("ovf",     32'h00140000,   16'd20,    0,  16'hFFFF,  16'd0,      1'b0, 1'b1);
        run_op("odd",     32'd1000,       16'd7,     16, 16'd142,   16'd6,      1'b0, 1'b0);
        run_op("one",     32'h0000ABCD,   16'd1,     16, 16'hABCD,  16'd0,      1'b0, 1'b0);

        // Start pulse mid-run must be ignored.
        begin_op(32'd1000, 16'd3);
        repeat (5) @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("ignore.latency", 64'(n + 6), 64'd16);
        check("ignore.quotient", 64'(quotient), 64'd333);
        check("ignore.remainder", 64'(remainder), 64'd1);
        $display("op ignore: 1000 / 3 -> q=%0d r=%0d", quotient, remainder);
        @(posedge clk); #1;

        // Reset mid-run aborts without a done pulse.
        begin_op(32'd5000, 16'd9);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.quotient", 64'(quotient), 64'd0);
        check("abort.remainder", 64'(remainder), 64'd0);
        check("abort.flags", 64'({div_by_zero, overflow}), 64'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) n++;
            @(posedge clk); #1;
        end
        check("abort.no_done", 64'(n), 64'd0);
        $display("op abort: done pulses after reset=%0d", n);
        run_op("post_abort", 32'd20000, 16'd100, 16, 16'd200, 16'd0, 1'b0, 1'b0);

        // Regression with start held high continuously.
        dvs = 16'($urandom_range(1, 65535));
        dvd = {16'($urandom_range(0, int'(dvs) - 1)), 16'($urandom)};
        dividend = dvd; divisor = dvs; start = 1'b1;
        cyc = 0; last_done = -1;
        for (int k = 0; k < 1000; k++) begin
            n = 0;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++; cyc++;
            end
            check("regr.done_seen", 64'(done), 64'd1);
            check("regr.invariant",
                  64'({(64'(quotient) * 64'(dvs) + 64'(remainder)) == 64'(dvd),
                       remainder < dvs, div_by_zero, overflow}),
                  64'b1100);
            if (last_done >= 0)
                check("regr.spacing", 64'(cyc - last_done), 64'd18);
            if (k < 3 || (k % 100) == 99)
                $display("regr %0d: %0d / %0d -> q=%0d r=%0d", k, dvd, dvs, quotient, remainder);
            last_done = cyc;
            dvs = 16'($urandom_range(1, 65535));
            dvd = {16'($urandom_range(0, int'(dvs) - 1)), 16'($urandom)};
            dividend = dvd; divisor = dvs;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider: the inverse of the team's 16x16 Dadda multiplier.
- Divides a 32-bit product-width dividend by a 16-bit divisor, giving a 16-bit quotient and a 16-bit remainder.
- Used in the ECG FIR datapath for gain normalisation and for checking multiplier results (product / b = a).
- Single clock, one quotient bit per cycle, start/done handshake.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width. Dividend is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request. Sampled only in IDLE.
- dividend  input  2*WIDTH  numerator, captured when start is accepted.
- divisor  input  WIDTH  denominator, captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results valid while high.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  error flag for the last operation.
- overflow  output  1  quotient did not fit in WIDTH bits.

Behaviour:
- Reset: all outputs 0; state IDLE; iteration counter 0.
- rst high at any edge, including mid-RUN, aborts the operation. No done pulse is issued.

States:
- IDLE: start=1 accepts the request at edge E0 and latches dividend and divisor.
  - If divisor==0: go to DONE; quotient={WIDTH{1}}, remainder=dividend[WIDTH-1:0], div_by_zero=1, overflow=0.
  - Else if dividend[2W-1:W] >= divisor: go to DONE; quotient={WIDTH{1}}, remainder=0, overflow=1, div_by_zero=0.
  - Else: go to RUN. Partial remainder R (WIDTH+1 bits) = dividend[2W-1:W]; shift register = dividend[W-1:0]; count=0; flags cleared.
- RUN: one iteration per edge, WIDTH edges total (E1..EW).
  - R' = {R[W-1:0], next dividend MSB}.
  - If R' >= {0,divisor}: R = R' - divisor, quotient bit = 1. Else R = R', bit = 0.
  - Quotient bits are shifted in MSB first.
  - At edge EW: quotient/remainder outputs are loaded and the state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.

Latency:
- Normal operation: done high in the cycle after edge E(WIDTH), i.e. 16 edges after acceptance for WIDTH=16.
- Error operation: done high in the cycle after E0.

Handshake and hold rules:
- start is ignored while busy=1. No queuing.
- start held continuously: the next request is accepted at the first edge in IDLE (one idle cycle between operations).
- quotient, remainder and flags hold their last values through IDLE. They change only when the next result loads.
- done and busy are never high in IDLE.

Arithmetic:
- Unsigned only.
- Invariant for non-error results: dividend == quotient*divisor + remainder, with remainder < divisor.
- The compare/subtract uses a WIDTH+1 bit width so the shifted-out MSB is not lost.

Test Plan:
- dividend=200, divisor=20 -> done 16 cycles after start; quotient=10, remainder=0, flags 0.
- dividend=4294836225 (0xFFFE0001), divisor=65535 -> quotient=65535, remainder=0. Then dividend=0xFFFEFFFF, divisor=65535 -> quotient=65535, remainder=65534.
- divisor=0, dividend=0x00001234 -> done 1 cycle after start; div_by_zero=1, quotient=0xFFFF, remainder=0x1234. Next valid operation clears the flag.
- dividend=0x00140000, divisor=20 -> overflow=1, quotient=0xFFFF, remainder=0, done after 1 cycle.
- Pulse start again at iteration 5 (ignored; result belongs to the first operands). Then assert rst at iteration 8 -> no done, all outputs 0, IDLE. A new start of 20000/100 afterwards returns 200 rem 0.
- Random regression: 1000 operand pairs with divisor != 0 and dividend[31:16] < divisor, start held high continuously -> every result satisfies the invariant. Consecutive done pulses are 18 cycles apart.
